// File: rtl/credit_receiver.sv
// Credit-flow receive buffer: DEPTH-entry circular store, registered output, one credit per released beat.
// Latency 1 cycle from write to out_valid; in_ready is held high outside reset (no backpressure) and beats arriving without space are dropped and flagged in the sticky overflow flag.
module credit_receiver #(
  parameter  int DEPTH        = 8,
  parameter  int NUM_ELEMENTS = 4,
  parameter  int ELEM_WIDTH   = 32,
  localparam int DW           = NUM_ELEMENTS * ELEM_WIDTH,
  localparam int AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  // beats from the credited sender
  input  logic [DW-1:0]           in_data,
  input  logic [NUM_ELEMENTS-1:0] in_keep,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  // beats to the downstream consumer
  output logic [DW-1:0]           out_data,
  output logic [NUM_ELEMENTS-1:0] out_keep,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  // status
  output logic                    credit_return,
  output logic [CW-1:0]           occupancy,
  output logic                    overflow
);

  logic [DW-1:0]           data_mem [DEPTH];
  logic [NUM_ELEMENTS-1:0] keep_mem [DEPTH];
  logic                    last_mem [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          ovf_q, ovf_d;
  logic          credit_q;

  logic deq;
  logic has_space;
  logic wr_en;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full buffer still accepts a beat when the head leaves in the same cycle.
  assign deq       = (occ_q != '0) && out_ready;
  assign has_space = (occ_q < CW'(DEPTH)) || deq;
  assign wr_en     = in_valid && has_space;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    ovf_d  = ovf_q;
    if (deq) begin
      head_d = ptr_inc(head_q);
    end
    if (wr_en) begin
      tail_d = ptr_inc(tail_q);
    end
    case ({wr_en, deq})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
    if (in_valid && !has_space) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      credit_q <= deq;
    end
  end

  // Storage is deliberately unreset; out_data is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      data_mem[tail_q] <= in_data;
      keep_mem[tail_q] <= in_keep;
      last_mem[tail_q] <= in_last;
    end
  end

  assign in_ready      = !rst;
  assign out_valid     = (occ_q != '0);
  assign out_data      = data_mem[head_q];
  assign out_keep      = keep_mem[head_q];
  assign out_last      = last_mem[head_q];
  assign credit_return = credit_q;
  assign occupancy     = occ_q;
  assign overflow      = ovf_q;

endmodule
